// File: rtl/conv_psum_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_psum_acc_pkg
// Brief    : Shared widths, FSM encoding and round/saturate helpers for the
//            partial-sum accumulator behind the 7x7 MAC array.
// Revision : 1.0 - initial release
// ============================================================================
package conv_psum_acc_pkg;

  // Defaults shared with the MAC array
  localparam int c_dw_def     = 8;
  localparam int c_cw_def     = 19;
  localparam int c_column_def = 7;
  localparam int c_ow_def     = 22;
  localparam int c_sw_def     = 5;

  localparam logic [1:0] c_fifo_depth = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Round-half-up arithmetic right shift; a zero shift passes through
  function automatic logic signed [63:0] round_shift(
    input logic signed [63:0] t,
    input logic        [7:0]  sh
  );
    logic signed [63:0] half;
    if (sh == 8'd0) return t;
    half = 64'sd1 <<< (sh - 8'd1);
    return (t + half) >>> sh;
  endfunction

  // Clamp to the signed range of a dw-bit result
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] r,
    input int unsigned        dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_psum_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_psum_acc_if
// Brief    : Partial-sum input stream, quantisation controls and quantised
//            output stream of the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_psum_acc_if
  import conv_psum_acc_pkg::*;
#(
  parameter int DW     = c_dw_def,
  parameter int CW     = c_cw_def,
  parameter int COLUMN = c_column_def,
  parameter int OW     = c_ow_def,
  parameter int SW     = c_sw_def
);
  logic [COLUMN*CW-1:0] s_data;
  logic                 s_valid;
  logic                 s_first;
  logic                 s_last;
  logic                 s_ready;
  logic [COLUMN*OW-1:0] bias;
  logic [SW-1:0]        shift;
  logic                 relu_en;
  logic [COLUMN*DW-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 busy;
  logic                 acc_err;

  // Producer/consumer side (MAC array + feature-map writer)
  modport master (
    output s_data, s_valid, s_first, s_last, bias, shift, relu_en, m_ready,
    input  s_ready, m_data, m_valid, busy, acc_err
  );

  // Accumulator side
  modport slave (
    input  s_data, s_valid, s_first, s_last, bias, shift, relu_en, m_ready,
    output s_ready, m_data, m_valid, busy, acc_err
  );
endinterface
`default_nettype wire

// File: rtl/conv_psum_acc_quant_lane.sv
`default_nettype none
// ============================================================================
// Module   : psum_quant_lane
// Brief    : One lane of post-processing: bias add, rounding shift, optional
//            ReLU and saturation to DW bits. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module psum_quant_lane
  import conv_psum_acc_pkg::*;
#(
  parameter int DW = c_dw_def,
  parameter int OW = c_ow_def,
  parameter int SW = c_sw_def
) (
  input  logic signed [OW-1:0] sum,
  input  logic signed [OW-1:0] bias,
  input  logic        [SW-1:0] shift,
  input  logic                 relu_en,
  output logic        [DW-1:0] q
);

  logic signed [OW:0]  w_t;
  logic signed [63:0]  w_t_ext;
  logic signed [63:0]  w_r;
  logic signed [63:0]  w_relu;

  // One guard bit so the bias add can never wrap
  assign w_t     = {sum[OW-1], sum} + {bias[OW-1], bias};
  assign w_t_ext = {{(63-OW){w_t[OW]}}, w_t};
  assign w_r     = round_shift(w_t_ext, 8'(shift));
  assign w_relu  = (relu_en && (w_r < 64'sd0)) ? 64'sd0 : w_r;
  assign q       = DW'(saturate(w_relu, DW));

endmodule
`default_nettype wire

// File: rtl/conv_psum_acc.sv
`default_nettype none
// ============================================================================
// Module   : conv_psum_acc
// Brief    : Accumulates per-column partial sums over a first/last delimited
//            tile, quantises the total and queues it in a 2-entry output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module conv_psum_acc
  import conv_psum_acc_pkg::*;
#(
  parameter int DW     = c_dw_def,
  parameter int CW     = c_cw_def,
  parameter int COLUMN = c_column_def,
  parameter int OW     = c_ow_def,
  parameter int SW     = c_sw_def
) (
  input  logic            clk,
  input  logic            rst,
  conv_psum_acc_if.slave  bus
);

  state_t               r_state;
  state_t               w_state_next;
  logic signed [OW-1:0] r_acc [COLUMN];
  logic signed [OW-1:0] w_sum [COLUMN];
  logic [COLUMN*DW-1:0] w_q;
  logic [COLUMN*DW-1:0] r_buf0;
  logic [COLUMN*DW-1:0] r_buf1;
  logic [1:0]           r_count;
  logic                 r_err;
  logic                 w_fire;
  logic                 w_load;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_err_set;
  logic                 w_wr_idx;

  // Ready depends only on buffer occupancy, never on m_ready
  assign bus.s_ready = (r_count != c_fifo_depth);
  assign w_fire      = bus.s_valid & bus.s_ready;
  assign w_pop       = bus.m_valid & bus.m_ready;
  assign bus.m_valid = (r_count != 2'd0);
  assign bus.m_data  = r_buf0;
  assign bus.busy    = (r_state == ST_ACC) || (r_count != 2'd0);
  assign bus.acc_err = r_err;

  // A push lands in slot 1 only when the head stays occupied this edge
  assign w_wr_idx = (r_count == 2'd1) && !w_pop;

  // Per-lane running sum including the current beat; s_first restarts it
  generate
    for (genvar k = 0; k < COLUMN; k++) begin : g_lane
      assign w_sum[k] = (bus.s_first ? '0 : r_acc[k])
                      + OW'($signed(bus.s_data[k*CW +: CW]));

      psum_quant_lane #(
        .DW (DW),
        .OW (OW),
        .SW (SW)
      ) u_quant (
        .sum     (w_sum[k]),
        .bias    (bus.bias[k*OW +: OW]),
        .shift   (bus.shift),
        .relu_en (bus.relu_en),
        .q       (w_q[k*DW +: DW])
      );
    end
  endgenerate

  // Tile FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Tile FSM: next state, accumulator load, result push and error detection
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_push       = 1'b0;
    w_err_set    = 1'b0;
    if (w_fire) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.s_first) begin
            w_load = 1'b1;
            if (bus.s_last) w_push       = 1'b1;
            else            w_state_next = ST_ACC;
          end else begin
            w_err_set = 1'b1;
          end
        end
        ST_ACC: begin
          w_load = 1'b1;
          if (bus.s_first) w_err_set = 1'b1;
          if (bus.s_last) begin
            w_push       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Accumulators follow the running sum on every accepted in-tile beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < COLUMN; k++) r_acc[k] <= '0;
    end else if (w_load) begin
      for (int k = 0; k < COLUMN; k++) r_acc[k] <= w_sum[k];
    end
  end

  // Sticky protocol error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  // Two-entry in-order output FIFO; slot 0 is always the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_count <= 2'd0;
    end else begin
      if (w_pop) r_buf0 <= r_buf1;
      if (w_push) begin
        if (w_wr_idx) r_buf1 <= w_q;
        else          r_buf0 <= w_q;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
